// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised register file, NRD registered read ports, one merging write port
// Storage is cleared by an init sequencer after reset; reads are write-first.
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic                              busy,
  input  logic [NRD-1:0]                    rd_en,
  input  logic [NRD*$clog2(DEPTH)-1:0]      rd_addr,
  output logic [NRD*WIDTH-1:0]              rd_data,
  input  logic                              wr_en,
  input  logic [$clog2(DEPTH)-1:0]          wr_addr,
  input  logic [1:0]                        wr_mode,
  input  logic [WIDTH-1:0]                  wr_data,
  output logic                              wr_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {INIT, READY} state_t;

  state_t            state, next_state;
  logic [AW-1:0]     init_ptr;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  old_val, wr_val;
  logic              wr_zero, wr_ok, wr_bad;
  logic [AW-1:0]     ra [NRD];
  logic [WIDTH-1:0]  rv [NRD];

  assign old_val = mem[wr_addr];
  assign wr_zero = (ZERO_REG != 0) && (wr_addr == '0);
  assign wr_ok   = wr_en && (state == READY) && (wr_mode != 2'b11) && !wr_zero;
  assign wr_bad  = wr_en && ((state == INIT) || (wr_mode == 2'b11));

  always_comb begin
    wr_val = wr_data;
    case (wr_mode)
      2'b01:   wr_val = {old_val[WIDTH-1:8],  wr_data[7:0]};
      2'b10:   wr_val = {old_val[WIDTH-1:16], wr_data[15:0]};
      default: wr_val = wr_data;
    endcase
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    case (state)
      INIT: begin
        busy = 1'b1;
        if (init_ptr == AW'(DEPTH - 1)) next_state = READY;
      end
      READY:   next_state = READY;
      default: next_state = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      init_ptr <= '0;
      wr_err   <= 1'b0;
    end else begin
      state    <= next_state;
      wr_err   <= wr_bad;
      if (state == INIT) init_ptr <= init_ptr + 1'b1;
    end
  end

  // No reset on the array itself: the sequencer clears it after reset.
  always_ff @(posedge clk) begin
    if (state == INIT) mem[init_ptr] <= '0;
    else if (wr_ok)    mem[wr_addr]  <= wr_val;
  end

  genvar g;
  generate
    for (g = 0; g < NRD; g++) begin : g_rd
      assign ra[g] = rd_addr[g*AW +: AW];
      assign rv[g] = ((ZERO_REG != 0) && (ra[g] == '0)) ? '0 :
                     (wr_ok && (ra[g] == wr_addr))       ? wr_val :
                                                           mem[ra[g]];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (state == READY) begin
      for (int i = 0; i < NRD; i++) begin
        if (rd_en[i]) rd_data[i*WIDTH +: WIDTH] <= rv[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - directed self-checking bench for regfile_param
module tb_regfile_param;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          busy;
  logic [1:0]    rd_en;
  logic [2*AW-1:0] rd_addr;
  logic [2*W-1:0]  rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_mode;
  logic [W-1:0]  wr_data;
  logic          wr_err;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_param #(.WIDTH(W), .DEPTH(D), .NRD(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .busy(busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_mode(wr_mode), .wr_data(wr_data),
    .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_mode = 2'b00; wr_addr = '0; wr_data = '0;
    rd_en = 2'b00; rd_addr = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [1:0] m, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_mode = m; wr_data = d;
  endtask

  task automatic rd(input int port, input logic [AW-1:0] a);
    rd_en[port] = 1'b1;
    rd_addr[port*AW +: AW] = a;
  endtask

  task automatic wait_ready(input string name);
    int cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    n_checks++;
    if (cnt !== D) begin
      n_fail++;
      $display("FAIL %s busy_cycles actual=%0d required=%0d", name, cnt, D);
    end
  endtask

  task automatic read_all_zero(input string name);
    for (int a = 0; a < D; a += 2) begin
      idle();
      rd(0, AW'(a));
      rd(1, AW'(a + 1));
      tick();
      n_checks++;
      if (rd_data !== 64'h0) begin
        n_fail++;
        $display("FAIL %s addr=%0d actual=%h required=0", name, a, rd_data);
      end
    end
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({busy, wr_err, rd_data} !== {1'b1, 1'b0, 64'h0}) begin
      n_fail++;
      $display("FAIL reset_state busy=%b wr_err=%b rd_data=%h required busy=1 wr_err=0 rd_data=0",
               busy, wr_err, rd_data);
    end
  endtask

  task automatic test_init();
    int cnt;
    rst = 1'b0;
    wr(4, 2'b00, 32'hFFFF_FFFF);
    rd(0, 4);
    tick();
    cnt = 1;
    n_checks++;
    if (wr_err !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_write_err actual=%b required=1", wr_err);
    end
    idle();
    tick();
    cnt++;
    n_checks++;
    if (wr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_write_err_width actual=%b required=0", wr_err);
    end
    while (busy === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    n_checks++;
    if (cnt !== D) begin
      n_fail++;
      $display("FAIL init_busy_cycles actual=%0d required=%0d", cnt, D);
    end
    read_all_zero("init_clear");
  endtask

  task automatic test_full_bypass();
    idle();
    wr(5, 2'b00, 32'hDEAD_BEEF);
    rd(0, 5);
    tick();
    n_checks++;
    if (rd_data[31:0] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL bypass_port0 actual=%h required=deadbeef", rd_data[31:0]);
    end
    idle();
    rd(1, 5);
    tick();
    n_checks++;
    if (rd_data[63:32] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL stored_port1 actual=%h required=deadbeef", rd_data[63:32]);
    end
    idle();
  endtask

  task automatic test_merge();
    idle();
    wr(7, 2'b00, 32'h1234_5678);
    tick();
    wr(7, 2'b01, 32'hFFFF_FFAB);
    tick();
    idle();
    rd(0, 7);
    rd(1, 7);
    tick();
    n_checks++;
    if (rd_data !== {32'h1234_56AB, 32'h1234_56AB}) begin
      n_fail++;
      $display("FAIL byte_merge actual=%h required=123456ab on both ports", rd_data);
    end
    idle();
    wr(7, 2'b10, 32'h0000_CDEF);
    rd(0, 7);
    tick();
    n_checks++;
    if (rd_data[31:0] !== 32'h1234_CDEF) begin
      n_fail++;
      $display("FAIL half_merge_bypass actual=%h required=1234cdef", rd_data[31:0]);
    end
    idle();
    rd(1, 7);
    tick();
    n_checks++;
    if (rd_data[63:32] !== 32'h1234_CDEF) begin
      n_fail++;
      $display("FAIL half_merge_stored actual=%h required=1234cdef", rd_data[63:32]);
    end
    idle();
  endtask

  task automatic test_zero_and_err();
    idle();
    wr(3, 2'b00, 32'h3333_3333);
    tick();
    wr(0, 2'b00, 32'hFFFF_FFFF);
    rd(1, 0);
    tick();
    n_checks++;
    if ({wr_err, rd_data[63:32]} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL zero_reg_write wr_err=%b rd=%h required wr_err=0 rd=0", wr_err, rd_data[63:32]);
    end
    idle();
    rd(0, 0);
    tick();
    n_checks++;
    if (rd_data[31:0] !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_reg_read actual=%h required=0", rd_data[31:0]);
    end
    idle();
    wr(3, 2'b11, 32'h0000_0000);
    rd(0, 3);
    tick();
    n_checks++;
    if ({wr_err, rd_data[31:0]} !== {1'b1, 32'h3333_3333}) begin
      n_fail++;
      $display("FAIL mode11_err wr_err=%b rd=%h required wr_err=1 rd=33333333", wr_err, rd_data[31:0]);
    end
    idle();
    rd(1, 3);
    tick();
    n_checks++;
    if ({wr_err, rd_data[63:32]} !== {1'b0, 32'h3333_3333}) begin
      n_fail++;
      $display("FAIL mode11_unchanged wr_err=%b rd=%h required wr_err=0 rd=33333333", wr_err, rd_data[63:32]);
    end
    idle();
  endtask

  task automatic test_rd_hold();
    idle();
    rd(0, 5);
    tick();
    n_checks++;
    if (rd_data[31:0] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL hold_initial actual=%h required=deadbeef", rd_data[31:0]);
    end
    idle();
    rd_addr[AW-1:0] = 5;
    wr(5, 2'b00, 32'h0000_0001);
    tick();
    idle();
    tick();
    n_checks++;
    if (rd_data[31:0] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL hold_disabled actual=%h required=deadbeef", rd_data[31:0]);
    end
    rd(0, 5);
    tick();
    n_checks++;
    if (rd_data[31:0] !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL hold_reenabled actual=%h required=00000001", rd_data[31:0]);
    end
    idle();
  endtask

  task automatic test_reset_mid_init();
    idle();
    rd(1, 7);
    tick();
    idle();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, rd_data} !== {1'b1, 64'h0}) begin
      n_fail++;
      $display("FAIL async_reset busy=%b rd_data=%h required busy=1 rd_data=0", busy, rd_data);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, wr_err, rd_data} !== {1'b1, 1'b0, 64'h0}) begin
      n_fail++;
      $display("FAIL mid_init_reset busy=%b wr_err=%b rd_data=%h required 1/0/0", busy, wr_err, rd_data);
    end
    tick();
    rst = 1'b0;
    wait_ready("reinit");
    read_all_zero("reinit_clear");
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_init();
    test_full_bypass();
    test_merge();
    test_zero_and_err();
    test_rd_hold();
    test_reset_mid_init();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
